// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: parametrised two-stage pipelined carry-lookahead adder.
//   Stage 1 forms per-bit propagate/generate, group P/G and the group carries
//   from a second-level lookahead. Stage 2 expands each group carry across its
//   bits and forms the sum and the carry out.
//   Flow control is valid/ready on both sides, one add per cycle when unstalled.
// Optional feature: define CLA_OVERFLOW_EN to add the 'ovf' output
// (signed overflow, registered alongside sum/cout).
module cla_adder_pipe #(
  parameter int WIDTH = 8,  // multiple of GROUP, >= GROUP
  parameter int GROUP = 4   // 2..8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / GROUP;

  // Carry into position n of a (g, p) chain seeded by ci, written as a flat
  // sum of products so the depth does not grow as a ripple.
  function automatic logic cla_carry(input logic [WIDTH-1:0] g,
                                     input logic [WIDTH-1:0] p,
                                     input logic             ci,
                                     input int               n);
    logic c;
    logic term;
    c = ci;
    for (int m = 0; m < n; m++) c = c & p[m];
    for (int j = 0; j < n; j++) begin
      term = g[j];
      for (int m = j + 1; m < n; m++) term = term & p[m];
      c = c | term;
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid;
  logic adv2;

  assign adv2     = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | adv2;

  // ---------------------------------------------------------------------
  // Stage 1 combinational: bit p/g, group P/G, group carries
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic [NG-1:0]    gp_in;
  logic [NG-1:0]    gg_in;
  logic [NG-1:0]    gc_in;

  assign p_in = a ^ b;
  assign g_in = a & b;

  // Group propagate/generate, then the second-level lookahead for group carries.
  always_comb begin
    // NOTE: every variable gets a default before any conditional or looped
    // assignment so no path leaves it holding an old value (no latch).
    gp_in = '0;
    gg_in = '0;
    gc_in = '0;
    for (int k = 0; k < NG; k++) begin
      gp_in[k] = &p_in[k*GROUP +: GROUP];
      gg_in[k] = cla_carry(WIDTH'(g_in[k*GROUP +: GROUP]),
                           WIDTH'(p_in[k*GROUP +: GROUP]), 1'b0, GROUP);
    end
    for (int k = 0; k < NG; k++) begin
      gc_in[k] = cla_carry(WIDTH'(gg_in), WIDTH'(gp_in), cin, k);
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;
  logic [NG-1:0]    s1_gc;
  logic             s1_cin;

  // Capture a new operand set whenever stage 1 is free to move.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
      s1_gc    <= '0;
      s1_cin   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p   <= p_in;
        s1_g   <= g_in;
        s1_gp  <= gp_in;
        s1_gg  <= gg_in;
        s1_gc  <= gc_in;
        s1_cin <= cin;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 combinational: in-group lookahead and word carry out
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             c_bit;

  // Expand each registered group carry across its bits; word carry out from group P/G.
  always_comb begin
    sum_nxt = '0;
    c_bit   = 1'b0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        c_bit = cla_carry(WIDTH'(s1_g[k*GROUP +: GROUP]),
                          WIDTH'(s1_p[k*GROUP +: GROUP]), s1_gc[k], i);
        sum_nxt[k*GROUP + i] = s1_p[k*GROUP + i] ^ c_bit;
      end
    end
    cout_nxt = cla_carry(WIDTH'(s1_gg), WIDTH'(s1_gp), s1_cin, NG);
  end

`ifdef CLA_OVERFLOW_EN
  // Carry into the sign bit, for signed overflow detection.
  logic msb_c;
  assign msb_c = cla_carry(WIDTH'(s1_g[WIDTH-GROUP +: GROUP]),
                           WIDTH'(s1_p[WIDTH-GROUP +: GROUP]),
                           s1_gc[NG-1], GROUP - 1);
`endif

  // ---------------------------------------------------------------------
  // Stage 2 registers / outputs
  // ---------------------------------------------------------------------
  // Load the result when the consumer side can move; hold everything while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_nxt;
        cout <= cout_nxt;
`ifdef CLA_OVERFLOW_EN
        ovf  <= msb_c ^ cout_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: randomised and directed checks of cla_adder_pipe at
// WIDTH=8/GROUP=4 and WIDTH=32/GROUP=8 against an arithmetic reference model.
module tb_cla_adder_pipe;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp8_t;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp32_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 8-bit instance signals
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
`ifdef CLA_OVERFLOW_EN
  logic       ovf;
`endif

  // 32-bit instance signals
  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [31:0] a32 = '0, b32 = '0;
  logic        cin32 = 1'b0;
  logic        out_valid32;
  logic        out_ready32 = 1'b1;
  logic [31:0] sum32;
  logic        cout32;
`ifdef CLA_OVERFLOW_EN
  logic        ovf32;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int n_out32 = 0;
  int stalls = 0;
  logic bp_mode = 1'b0;
  logic tp_mode = 1'b0;

  exp8_t  q8[$];
  exp32_t q32[$];

  cla_adder_pipe #(.WIDTH(8), .GROUP(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CLA_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  cla_adder_pipe #(.WIDTH(32), .GROUP(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .cout(cout32)
`ifdef CLA_OVERFLOW_EN
    , .ovf(ovf32)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Reference model: plain wide addition, overflow from operand/result signs.
  function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    logic [8:0] t;
    exp8_t e;
    t   = {1'b0, x} + {1'b0, y} + 9'(ci);
    e.s = t[7:0];
    e.c = t[8];
    e.o = (x[7] == y[7]) && (t[7] != x[7]);
    return e;
  endfunction

  function automatic exp32_t model32(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    exp32_t e;
    t   = {1'b0, x} + {1'b0, y} + 33'(ci);
    e.s = t[31:0];
    e.c = t[32];
    e.o = (x[31] == y[31]) && (t[31] != x[31]);
    return e;
  endfunction

  // Consumer-side ready: random under backpressure, otherwise always ready.
  always @(posedge clk) begin
    #1;
    out_ready   = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    out_ready32 = 1'($urandom_range(0, 1));
  end

  // 8-bit monitor: scoreboard on handshakes, stability while stalled.
  logic       held8 = 1'b0;
  logic [7:0] last_sum;
  logic       last_cout;
  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      held8 = 1'b0;
    end else begin
      if (in_valid && in_ready) q8.push_back(model8(a, b, cin));
      if (tp_mode && in_valid && !in_ready) stalls++;
      if (held8) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_sum", 64'(sum), 64'(last_sum));
        check("hold_cout", 64'(cout), 64'(last_cout));
      end
      if (out_valid && out_ready) begin
        if (q8.size() == 0) fail("out8_unexpected_result");
        else begin
          exp8_t e;
          e = q8.pop_front();
          check("out8_sum", 64'(sum), 64'(e.s));
          check("out8_cout", 64'(cout), 64'(e.c));
`ifdef CLA_OVERFLOW_EN
          check("out8_ovf", 64'(ovf), 64'(e.o));
`endif
        end
        n_out++;
      end
      held8     = out_valid && !out_ready;
      last_sum  = sum;
      last_cout = cout;
    end
  end

  // 32-bit monitor.
  always @(negedge clk) begin
    if (rst) q32.delete();
    else begin
      if (in_valid32 && in_ready32) q32.push_back(model32(a32, b32, cin32));
      if (out_valid32 && out_ready32) begin
        if (q32.size() == 0) fail("out32_unexpected_result");
        else begin
          exp32_t e;
          e = q32.pop_front();
          check("out32_sum", 64'(sum32), 64'(e.s));
          check("out32_cout", 64'(cout32), 64'(e.c));
`ifdef CLA_OVERFLOW_EN
          check("out32_ovf", 64'(ovf32), 64'(e.o));
`endif
        end
        n_out32++;
      end
    end
  end

  // Present one operand set; returns 1 ns after the edge that accepted it.
  task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    bit ok;
    ok = 1'b0;
    a = x; b = y; cin = ci; in_valid = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("drive8_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive32(input logic [31:0] x, input logic [31:0] y, input logic ci);
    bit ok;
    ok = 1'b0;
    a32 = x; b32 = y; cin32 = ci; in_valid32 = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (in_ready32) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("drive32_timeout");
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
  endtask

  task automatic drain8();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (q8.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("drain8_timeout");
    @(posedge clk);
    #1;
  endtask

  // Single op on an idle pipe: model pinned to literals, DUT valid exactly 2 cycles later.
  task automatic directed(input string nm, input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input logic [7:0] es, input logic ec,
                          input logic eo);
    exp8_t m;
    m = model8(x, y, ci);
    check({nm, "_model_sum"}, 64'(m.s), 64'(es));
    check({nm, "_model_cout"}, 64'(m.c), 64'(ec));
    check({nm, "_model_ovf"}, 64'(m.o), 64'(eo));
    drive8(x, y, ci);
    @(posedge clk);
    #1;
    check({nm, "_valid_at_2"}, 64'(out_valid), 64'd1);
    check({nm, "_sum"}, 64'(sum), 64'(es));
    check({nm, "_cout"}, 64'(cout), 64'(ec));
`ifdef CLA_OVERFLOW_EN
    check({nm, "_ovf"}, 64'(ovf), 64'(eo));
`endif
    drain8();
  endtask

  initial begin
    logic [7:0] bset [8];
    int base;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic and cross-group carries
    directed("basic_2p3", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);
    directed("basic_zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    directed("wrap_ff_cin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    directed("grp_carry", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    directed("ovf_7f_1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    directed("ovf_80_ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    directed("ovf_05_fb", 8'h05, 8'hFB, 1'b0, 8'h00, 1'b1, 1'b0);

    // Reset with two operations in flight
    drive8(8'h33, 8'h44, 1'b0);
    drive8(8'h21, 8'h12, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_no_output", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Backpressure stream 0x10+k + 1
    bp_mode = 1'b1;
    base = n_out;
    for (int k = 0; k < 10; k++) begin
      check("bp_model", 64'(model8(8'h10 + 8'(k), 8'h01, 1'b0).s), 64'(8'h11 + 8'(k)));
      drive8(8'h10 + 8'(k), 8'h01, 1'b0);
    end
    drain8();
    check("bp_result_count", 64'(n_out - base), 64'd10);
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Throughput: 100 random ops, no stalls expected
    tp_mode = 1'b1;
    base = n_out;
    for (int k = 0; k < 100; k++)
      drive8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    tp_mode = 1'b0;
    drain8();
    check("tp_stalls", 64'(stalls), 64'd0);
    check("tp_result_count", 64'(n_out - base), 64'd100);

    // Sweep all a against corner and random b, both carry-ins, random backpressure
    bp_mode = 1'b1;
    for (int x = 0; x < 256; x++) begin
      bset[0] = 8'h00; bset[1] = 8'h01; bset[2] = 8'h7F; bset[3] = 8'h80; bset[4] = 8'hFF;
      bset[5] = 8'($urandom); bset[6] = 8'($urandom); bset[7] = 8'($urandom);
      for (int j = 0; j < 8; j++)
        for (int ci = 0; ci < 2; ci++)
          drive8(8'(x), bset[j], 1'(ci));
    end
    drain8();
    bp_mode = 1'b0;

    // 32-bit / GROUP=8 random stream with random backpressure
    base = n_out32;
    drive32(32'hFFFF_FFFF, 32'h0, 1'b1);
    drive32(32'h7FFF_FFFF, 32'h1, 1'b0);
    for (int k = 0; k < 300; k++)
      drive32($urandom, $urandom, 1'($urandom_range(0, 1)));
    begin
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 2000; t++) begin
        @(negedge clk);
        if (q32.size() == 0 && !out_valid32) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail("drain32_timeout");
    end
    check("w32_result_count", 64'(n_out32 - base), 64'd302);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
